// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the streaming matrix multiply engine.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Element counts of A, B and C for a given shape.
  function automatic int a_elems(input int r_a, input int c_a);
    return r_a * c_a;
  endfunction

  function automatic int b_elems(input int c_a, input int c_b);
    return c_a * c_b;
  endfunction

  function automatic int c_elems(input int r_a, input int c_b);
    return r_a * c_b;
  endfunction

  // Accumulator width large enough that a full dot product never overflows.
  function automatic int acc_w(input int dw, input int c_a);
    return 2 * dw + $clog2(c_a) + 1;
  endfunction

  localparam int DEF_ACC_W = acc_w(16, 4);

endpackage

// File: rtl/matmul_stream_engine_if.sv
// Operand/result stream bundle between the engine and its environment.
// Every stream is valid/ready: a beat transfers on a rising edge where both
// valid and ready are high; the sender holds valid and data stable until then,
// and the receiver may raise or drop ready at any time.
interface matmul_stream_engine_if
  import matmul_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ACC_W = DEF_ACC_W,
  parameter int IW    = 16
);
  logic             start;
  logic             a_valid;
  logic             a_ready;
  logic [DW-1:0]    a_data;
  logic             b_valid;
  logic             b_ready;
  logic [DW-1:0]    b_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [IW-1:0]    res_i;
  logic [IW-1:0]    res_j;
  logic             res_last;
  logic             busy;
  logic             done;

  // Environment side: sources operands, sinks results.
  modport master (
    output start, a_valid, a_data, b_valid, b_data, res_ready,
    input  a_ready, b_ready, res_valid, res_data, res_i, res_j, res_last, busy, done
  );

  // Engine side.
  modport slave (
    input  start, a_valid, a_data, b_valid, b_data, res_ready,
    output a_ready, b_ready, res_valid, res_data, res_i, res_j, res_last, busy, done
  );
endinterface

// File: rtl/matmul_stream_engine_mac_unit.sv
// Single signed multiply-accumulate: acc <= clr ? 0 : acc + sext(a*b) when en.
module mac_unit #(
  parameter int DW    = 16,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);
  logic [2*DW-1:0]         prod;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  // Full-width product of sign-extended operands, then sign-extend into the accumulator.
  always_comb begin
    prod  = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/matmul_stream_engine.sv
// Buffers A and B from two streams, computes C = A*B one product per cycle,
// and emits C row-major with row/column tags on a backpressured stream.
module matmul_stream_engine
  import matmul_pkg::*;
#(
  parameter int DW    = 16,
  parameter int R_A   = 2,
  parameter int C_A   = 4,
  parameter int C_B   = 2,
  parameter int ACC_W = acc_w(DW, C_A),
  parameter int IW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  matmul_stream_engine_if.slave  io,
  output state_e                 dbg_state
);
  localparam int NA  = a_elems(R_A, C_A);
  localparam int NB  = b_elems(C_A, C_B);
  localparam int ACW = $clog2(NA + 1);
  localparam int BCW = $clog2(NB + 1);
  localparam int KW  = $clog2(C_A + 1);
  localparam int AAW = (NA > 1) ? $clog2(NA) : 1;
  localparam int BAW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [ACW-1:0] NA_C   = ACW'(NA);
  localparam logic [BCW-1:0] NB_C   = BCW'(NB);
  localparam logic [KW-1:0]  LAST_K = KW'(C_A - 1);
  localparam logic [IW-1:0]  LAST_I = IW'(R_A - 1);
  localparam logic [IW-1:0]  LAST_J = IW'(C_B - 1);

  state_e             state_d, state_q;
  logic [ACW-1:0]     a_cnt_d, a_cnt_q;
  logic [BCW-1:0]     b_cnt_d, b_cnt_q;
  logic [IW-1:0]      i_d, i_q, j_d, j_q;
  logic [KW-1:0]      k_d, k_q;
  logic signed [DW-1:0] a_buf_q [NA];
  logic signed [DW-1:0] b_buf_q [NB];

  logic               a_ready, b_ready, a_fire, b_fire;
  logic               res_last;
  logic               mac_clr, mac_en;
  logic [AAW-1:0]     a_addr;
  logic [BAW-1:0]     b_addr;
  logic signed [ACC_W-1:0] acc;

  assign a_ready  = (state_q == LOAD) && (a_cnt_q < NA_C);
  assign b_ready  = (state_q == LOAD) && (b_cnt_q < NB_C);
  assign a_fire   = io.a_valid && a_ready;
  assign b_fire   = io.b_valid && b_ready;
  assign res_last = (state_q == OUT) && (i_q == LAST_I) && (j_q == LAST_J);
  assign a_addr   = AAW'(int'(i_q) * C_A + int'(k_q));
  assign b_addr   = BAW'(int'(k_q) * C_B + int'(j_q));

  // Next-state, counters and MAC control.
  always_comb begin
    state_d = state_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = LOAD;
          a_cnt_d = '0;
          b_cnt_d = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      LOAD: begin
        if (a_fire) a_cnt_d = a_cnt_q + ACW'(1);
        if (b_fire) b_cnt_d = b_cnt_q + BCW'(1);
        // Look at the post-transfer counts so the first MAC follows the last beat directly.
        if ((a_cnt_d == NA_C) && (b_cnt_d == NB_C)) begin
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == LAST_K) begin
          state_d = OUT;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      OUT: begin
        if (io.res_ready) begin
          if (res_last) begin
            state_d = DONE;
          end else begin
            state_d = MAC;
            mac_clr = 1'b1;
            if (j_q == LAST_J) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + IW'(1);
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Operand capture; buffer contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (a_fire) a_buf_q[AAW'(a_cnt_q)] <= io.a_data;
    if (b_fire) b_buf_q[BAW'(b_cnt_q)] <= io.b_data;
  end

  mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (a_buf_q[a_addr]),
    .b     (b_buf_q[b_addr]),
    .acc   (acc)
  );

  // The accumulator is idle during OUT, so it doubles as the result register.
  // The indices are likewise held until the handshake advances them.
  assign io.a_ready   = a_ready;
  assign io.b_ready   = b_ready;
  assign io.res_valid = (state_q == OUT);
  assign io.res_data  = acc;
  assign io.res_i     = i_q;
  assign io.res_j     = j_q;
  assign io.res_last  = res_last;
  assign io.busy      = (state_q != IDLE);
  assign io.done      = (state_q == DONE);
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_matmul_stream_engine.sv
// Directed and randomized checks of matmul_stream_engine against a dot-product model.
module tb_matmul_stream_engine;
  import matmul_pkg::*;

  localparam int DW    = 16;
  localparam int R_A   = 2;
  localparam int C_A   = 4;
  localparam int C_B   = 2;
  localparam int ACC_W = acc_w(DW, C_A);
  localparam int IW    = 16;
  localparam int NA    = R_A * C_A;
  localparam int NB    = C_A * C_B;
  localparam int NC    = R_A * C_B;
  localparam int MAX_LOAD = (NA > NB) ? NA : NB;
  localparam int TMO   = 400;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     done_seen = 0;
  int     start_cyc, done_cyc;

  logic signed [DW-1:0] a_m [NA];
  logic signed [DW-1:0] b_m [NB];
  logic [ACC_W-1:0]     exp_q [$];

  matmul_stream_engine_if #(.DW(DW), .ACC_W(ACC_W), .IW(IW)) io ();

  matmul_stream_engine #(
    .DW(DW), .R_A(R_A), .C_A(C_A), .C_B(C_B), .ACC_W(ACC_W), .IW(IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (io),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (io.done === 1'b1) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: no response within %0d cycles", tag, TMO);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_ready"},   io.a_ready,   0);
    check({tag, "_b_ready"},   io.b_ready,   0);
    check({tag, "_res_valid"}, io.res_valid, 0);
    check({tag, "_res_data"},  io.res_data,  0);
    check({tag, "_res_i"},     io.res_i,     0);
    check({tag, "_res_j"},     io.res_j,     0);
    check({tag, "_res_last"},  io.res_last,  0);
    check({tag, "_busy"},      io.busy,      0);
    check({tag, "_done"},      io.done,      0);
  endtask

  // Reference model: plain dot products over the row-major operand arrays.
  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < R_A; i++)
      for (int j = 0; j < C_B; j++) begin
        longint s = 0;
        for (int k = 0; k < C_A; k++)
          s += longint'(a_m[i*C_A+k]) * longint'(b_m[k*C_B+j]);
        exp_q.push_back(ACC_W'(s));
      end
  endtask

  task automatic set_rand();
    for (int x = 0; x < NA; x++) a_m[x] = DW'($urandom);
    for (int x = 0; x < NB; x++) b_m[x] = DW'($urandom);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_a(input int gap);
    for (int x = 0; x < NA; x++) begin
      int w = 0;
      int g = (gap > 0) ? $urandom_range(1, gap) : 0;
      repeat (g) begin io.a_valid = 1'b0; @(negedge clk); end
      io.a_valid = 1'b1;
      io.a_data  = a_m[x];
      while (!io.a_ready && w < TMO) begin @(negedge clk); w++; end
      if (w >= TMO) begin timeout_fail("a_ready_wait"); io.a_valid = 1'b0; return; end
      @(negedge clk);
    end
    io.a_valid = 1'b0;
  endtask

  task automatic drive_b(input int gap, input bit junk_after);
    for (int x = 0; x < NB; x++) begin
      int w = 0;
      int g = (gap > 0) ? $urandom_range(1, gap) : 0;
      repeat (g) begin io.b_valid = 1'b0; @(negedge clk); end
      io.b_valid = 1'b1;
      io.b_data  = b_m[x];
      while (!io.b_ready && w < TMO) begin @(negedge clk); w++; end
      if (w >= TMO) begin timeout_fail("b_ready_wait"); io.b_valid = 1'b0; return; end
      @(negedge clk);
    end
    // Keep offering a bogus beat after B is full; it must not be taken.
    io.b_valid = junk_after;
    io.b_data  = 16'h1234;
  endtask

  task automatic collect(input int n_col, input int stall_elem, input int stall_n, input bit pulse);
    for (int e = 0; e < n_col; e++) begin
      int w = 0;
      logic [ACC_W-1:0] exp_d;
      logic [IW-1:0] ei, ej;
      exp_d = exp_q.pop_front();
      ei = IW'(e / C_B);
      ej = IW'(e % C_B);
      while (!io.res_valid && w < TMO) begin @(negedge clk); w++; end
      if (w >= TMO) begin timeout_fail("res_valid_wait"); return; end
      if (e == stall_elem) begin
        io.res_ready = 1'b0;
        repeat (stall_n) begin
          check("stall_valid", io.res_valid, 1);
          check("stall_data",  io.res_data,  exp_d);
          check("stall_i",     io.res_i,     ei);
          check("stall_j",     io.res_j,     ej);
          @(negedge clk);
        end
        io.res_ready = 1'b1;
      end
      if (pulse && e == 0) io.start = 1'b1;
      check("res_data", io.res_data, exp_d);
      check("res_i",    io.res_i,    ei);
      check("res_j",    io.res_j,    ej);
      check("res_last", io.res_last, (e == NC - 1) ? 1 : 0);
      @(negedge clk);
      io.start = 1'b0;
    end
    if (n_col == NC) begin
      done_cyc = cyc;
      check("done_pulse", io.done, 1);
      check("done_busy",  io.busy, 1);
      check("done_resv",  io.res_valid, 0);
      if (pulse) io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      check("done_clear", io.done, 0);
      check("idle_busy",  io.busy, 0);
    end
  endtask

  task automatic run_job(input int gap_a, input int gap_b, input bit junk_b,
                         input int stall_elem, input int stall_n, input bit pulse,
                         input int n_col);
    done_seen = 0;
    io.res_ready = 1'b1;
    @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    start_cyc = cyc;
    check("start_busy",    io.busy,    1);
    check("start_a_ready", io.a_ready, 1);
    check("start_b_ready", io.b_ready, 1);
    fork
      drive_a(gap_a);
      drive_b(gap_b, junk_b);
      collect(n_col, stall_elem, stall_n, pulse);
      begin
        if (pulse) begin
          @(negedge clk); io.start = 1'b1;
          @(negedge clk); io.start = 1'b0;
        end
      end
    join
    io.b_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    io.start = 1'b0; io.a_valid = 1'b0; io.b_valid = 1'b0;
    io.a_data = '0; io.b_data = '0; io.res_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", io.busy, 0);

    // 1: sequential operands, back-to-back, fixed reference results.
    for (int x = 0; x < NA; x++) a_m[x] = DW'(x + 1);
    for (int x = 0; x < NB; x++) b_m[x] = DW'(x + 1);
    exp_q.delete();
    exp_q.push_back(ACC_W'(50));
    exp_q.push_back(ACC_W'(60));
    exp_q.push_back(ACC_W'(114));
    exp_q.push_back(ACC_W'(140));
    run_job(0, 0, 1'b0, -1, 0, 1'b0, NC);
    check("min_job_latency", done_cyc - start_cyc, MAX_LOAD + NC * (C_A + 1));
    check("s1_done_count", done_seen, 1);

    // 2: most negative operands; the sum must not wrap.
    for (int x = 0; x < NA; x++) a_m[x] = -16'sd32768;
    for (int x = 0; x < NB; x++) b_m[x] = -16'sd32768;
    exp_q.delete();
    repeat (NC) exp_q.push_back(35'h1_0000_0000);
    run_job(0, 0, 1'b0, -1, 0, 1'b0, NC);

    // 3: gaps on A so B completes first; junk offered while readys are low.
    for (int x = 0; x < NA; x++) a_m[x] = DW'(x + 1);
    for (int x = 0; x < NB; x++) b_m[x] = DW'(x + 1);
    io.a_valid = 1'b1; io.a_data = 16'h7fff;
    io.b_valid = 1'b1; io.b_data = 16'h7fff;
    repeat (2) @(negedge clk);
    check("idle_a_ready", io.a_ready, 0);
    check("idle_b_ready", io.b_ready, 0);
    exp_q.delete();
    exp_q.push_back(ACC_W'(50));
    exp_q.push_back(ACC_W'(60));
    exp_q.push_back(ACC_W'(114));
    exp_q.push_back(ACC_W'(140));
    run_job(3, 0, 1'b1, -1, 0, 1'b0, NC);

    // 4: backpressure on C[0][1] for five cycles.
    exp_q.delete();
    exp_q.push_back(ACC_W'(50));
    exp_q.push_back(ACC_W'(60));
    exp_q.push_back(ACC_W'(114));
    exp_q.push_back(ACC_W'(140));
    run_job(0, 0, 1'b0, 1, 5, 1'b0, NC);

    // 5: start pulsed in LOAD, OUT and on the DONE->IDLE edge must be ignored.
    set_rand();
    build_model();
    run_job(0, 0, 1'b0, -1, 0, 1'b1, NC);
    repeat (4) @(negedge clk);
    check("pulse_done_count", done_seen, 1);
    check("pulse_stay_idle",  io.busy, 0);

    // 6: reset while computing C[1][0], then a clean job with new data.
    set_rand();
    build_model();
    run_job(0, 0, 1'b0, -1, 0, 1'b0, 2);
    exp_q.delete();
    check("pre_reset_busy", io.busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_mac_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset_idle", io.busy, 0);
    set_rand();
    build_model();
    run_job(0, 0, 1'b0, -1, 0, 1'b0, NC);

    // 7: random operands, gaps and stalls.
    for (int r = 0; r < 4; r++) begin
      set_rand();
      build_model();
      run_job($urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
              $urandom_range(0, NC - 1), $urandom_range(1, 4), 1'b0, NC);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
